// File: rtl/fnd_scan_ctrl_n.sv
// fnd_scan_ctrl_n: multi-digit 7-segment scan controller.
// Accepts a binary value over a valid/ready handshake, converts it to BCD
// with a sequential double-dabble engine, commits the result atomically and
// scans NUM_DIGITS common-anode digits with leading-zero blanking, per-digit
// decimal points and an overflow indication.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_data/in_valid    binary value and its valid strobe
//   in_ready            converter idle, a transfer is accepted
//   dp_mask             decimal point per digit (bit0 = units, 1 = lit), live
//   blank_lz            1 = blank leading zeros, live
//   an                  digit enables, active-low one-hot
//   seg                 {dp,g,f,e,d,c,b,a}, active-low
//   overflow            committed value does not fit NUM_DIGITS digits
module fnd_scan_ctrl_n #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned IN_WIDTH     = 14,
   parameter int unsigned DIGIT_PERIOD = 100_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   input  logic                  blank_lz,
   output logic [NUM_DIGITS-1:0] an,
   output logic [7:0]            seg,
   output logic                  overflow
);

   localparam int unsigned BCD_W  = 4 * (NUM_DIGITS + 1);
   localparam int unsigned DISP_W = 4 * NUM_DIGITS;
   localparam int unsigned DD_W   = BCD_W + IN_WIDTH;
   localparam int unsigned CNT_W  = $clog2(IN_WIDTH + 1);
   localparam int unsigned DIV_W  = $clog2(DIGIT_PERIOD);
   localparam int unsigned SEL_W  = $clog2(NUM_DIGITS);
   localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_next;
   logic [DD_W-1:0]       r_dd;        // {bcd, shift register}
   logic [BCD_W-1:0]      w_adj;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_ovf_lat;
   logic [DISP_W-1:0]     r_disp;
   logic                  r_ovf;
   logic                  r_in_ready;
   logic [DIV_W-1:0]      r_div;
   logic [SEL_W-1:0]      r_sel;
   logic [NUM_DIGITS-1:0] r_an;
   logic [7:0]            r_seg;
   logic [NUM_DIGITS-1:0] w_an;
   logic [3:0]            w_nib;
   logic                  w_dp;
   logic                  w_lz;
   logic [6:0]            w_pat;
   logic [7:0]            w_seg;

   // Converter state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Converter next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == CNT_W'(1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Double-dabble add-3 correction on every nibble (one spare nibble keeps carries)
   always_comb begin
      logic [3:0] nib;
      nib   = '0;
      w_adj = '0;
      for (int unsigned k = 0; k < NUM_DIGITS + 1; k++) begin
         nib = r_dd[IN_WIDTH + 4*k +: 4];
         w_adj[4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   end

   // Conversion datapath and atomic commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dd       <= '0;
         r_cnt      <= '0;
         r_ovf_lat  <= 1'b0;
         r_disp     <= '0;
         r_ovf      <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_dd       <= {BCD_W'(0), in_data};
               r_cnt      <= CNT_W'(IN_WIDTH);
               r_ovf_lat  <= (32'(in_data) > MAX_VAL);
               r_in_ready <= 1'b0;
            end
            S_SHIFT: begin
               r_dd  <= {w_adj, r_dd[IN_WIDTH-1:0]} << 1;
               r_cnt <= r_cnt - CNT_W'(1);
            end
            S_DONE: begin
               r_disp     <= r_dd[IN_WIDTH +: DISP_W];
               r_ovf      <= r_ovf_lat;
               r_in_ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Refresh divider and digit select
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div <= '0;
         r_sel <= '0;
      end else if (r_div == DIV_W'(DIGIT_PERIOD - 1)) begin
         r_div <= '0;
         r_sel <= (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + SEL_W'(1);
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Digit decode for the selected slot
   always_comb begin
      w_an  = '1;
      w_nib = '0;
      w_dp  = 1'b1;
      w_lz  = 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (SEL_W'(k) == r_sel) begin
            w_an[k] = 1'b0;
            w_nib   = r_disp[4*k +: 4];
            w_dp    = ~dp_mask[k];
            // digit k and everything above it are zero; units never blank
            w_lz    = (k != 0) && ((r_disp >> (4*k)) == '0);
         end
      end
      case (w_nib)
         4'd0:    w_pat = 7'h40;
         4'd1:    w_pat = 7'h79;
         4'd2:    w_pat = 7'h24;
         4'd3:    w_pat = 7'h30;
         4'd4:    w_pat = 7'h19;
         4'd5:    w_pat = 7'h12;
         4'd6:    w_pat = 7'h02;
         4'd7:    w_pat = 7'h78;
         4'd8:    w_pat = 7'h00;
         4'd9:    w_pat = 7'h10;
         default: w_pat = 7'h7F;
      endcase
      if (r_ovf)                w_seg = {w_dp, 7'h3F};
      else if (blank_lz && w_lz) w_seg = {w_dp, 7'h7F};
      else                      w_seg = {w_dp, w_pat};
   end

   // Registered pin drivers, one cycle behind the select
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_an  <= '1;
         r_seg <= 8'hFF;
      end else begin
         r_an  <= w_an;
         r_seg <= w_seg;
      end
   end

   assign an       = r_an;
   assign seg      = r_seg;
   assign in_ready = r_in_ready;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_fnd_scan_ctrl_n.sv
// Self-checking bench for fnd_scan_ctrl_n (4 digits, 14-bit input, 4-clk slots).
module tb_fnd_scan_ctrl_n;

   localparam int ND = 4;
   localparam int IW = 14;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [IW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [ND-1:0] dp_mask;
   logic          blank_lz;
   logic [ND-1:0] an;
   logic [7:0]    seg;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   fnd_scan_ctrl_n #(.NUM_DIGITS(ND), .IN_WIDTH(IW), .DIGIT_PERIOD(DP)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .dp_mask(dp_mask), .blank_lz(blank_lz),
      .an(an), .seg(seg), .overflow(overflow)
   );

   always #5 clk = ~clk;

   logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected segment byte for a digit slot from the decimal value
   function automatic logic [7:0] exp_seg(input int sel, input int disp, input bit ovf,
                                          input logic [ND-1:0] dpm, input logic blz);
      int p = 1;
      logic [6:0] s;
      for (int i = 0; i < sel; i++) p = p * 10;
      if (ovf)                          s = 7'h3F;
      else if (sel > 0 && blz && disp < p) s = 7'h7F;
      else                              s = pat[(disp / p) % 10][6:0];
      return {~dpm[sel], s};
   endfunction

   // Behavioural model: cycle count since reset, busy countdown, decimal display value
   int         m_cyc, m_busy, m_pend, m_disp;
   bit         m_ovf, m_on;
   logic [3:0] e_an;
   logic [7:0] e_seg;
   logic       e_rdy;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cyc <= 0; m_busy <= 0; m_disp <= 0; m_ovf <= 1'b0; m_on <= 1'b1;
         e_an <= 4'hF; e_seg <= 8'hFF; e_rdy <= 1'b1;
      end else begin
         e_an  <= ~(4'(4'b0001 << ((m_cyc / DP) % ND)));
         e_seg <= exp_seg((m_cyc / DP) % ND, m_disp, m_ovf, dp_mask, blank_lz);
         m_cyc <= m_cyc + 1;
         if (m_busy == 0) begin
            if (in_valid) begin
               m_pend <= int'(in_data);
               m_busy <= IW + 1;
               e_rdy  <= 1'b0;
            end
         end else begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
               m_disp <= m_pend % 10000;
               m_ovf  <= (m_pend > 9999);
               e_rdy  <= 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_on) begin
         chk("an", 32'(an), 32'(e_an));
         chk("seg", 32'(seg), 32'(e_seg));
         chk("in_ready", 32'(in_ready), 32'(e_rdy));
         chk("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send(input int v);
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
      in_data  = IW'(v);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic get_digit(input int k, output logic [7:0] s);
      int n = 0;
      logic [3:0] want;
      want = ~(4'(4'b0001 << k));
      repeat (2) @(negedge clk);
      while (an !== want && n < 40) begin @(negedge clk); n++; end
      if (n >= 40) chk("digit_timeout", 32'(an), 32'(want));
      s = seg;
   endtask

   task automatic check_digits(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] s;
      logic [7:0] ex [4];
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      for (int k = 0; k < 4; k++) begin
         get_digit(k, s);
         chk($sformatf("%s_d%0d", nm, k), 32'(s), 32'(ex[k]));
      end
   endtask

   initial begin
      int n;
      in_valid = 1'b0; in_data = '0; dp_mask = '0; blank_lz = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_ovf", 32'(overflow), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: idle display, then leading-zero blanking; slot length
      check_digits("t1_nolz", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      blank_lz = 1'b1;
      check_digits("t1_lz", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
      n = 0;
      while (an !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
      n = 0;
      while (an === 4'b1110 && n < 40) begin @(negedge clk); n++; end
      n = 0;
      while (an === 4'b1101 && n < 40) begin @(negedge clk); n++; end
      chk("t1_slot_len", 32'(n), 32'd4);
      chk("t1_next_an", 32'(an), 32'b1011);
      blank_lz = 1'b0;

      // 2: 1234, ready low for exactly IW+1 samples
      send(1234);
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin n++; @(negedge clk); end
      chk("t2_busy_len", 32'(n), 32'd15);
      check_digits("t2", 8'h99, 8'hB0, 8'hA4, 8'hF9);
      chk("t2_ovf", 32'(overflow), 32'd0);

      // 3: largest fitting value, then overflow values
      send(9999); wait_ready();
      check_digits("t3_9999", 8'h90, 8'h90, 8'h90, 8'h90);
      chk("t3_ovf0", 32'(overflow), 32'd0);
      send(10000); wait_ready();
      chk("t3_ovf1", 32'(overflow), 32'd1);
      check_digits("t3_10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
      send(16383); wait_ready();
      chk("t3_ovf2", 32'(overflow), 32'd1);
      dp_mask = 4'b0100;
      check_digits("t3_dp", 8'hBF, 8'hBF, 8'h3F, 8'hBF);

      // 4: blanking with a decimal point on a blanked digit
      blank_lz = 1'b1; dp_mask = 4'b0010;
      send(7); wait_ready();
      check_digits("t4", 8'hF8, 8'h7F, 8'hFF, 8'hFF);
      chk("t4_ovf", 32'(overflow), 32'd0);

      // 5: request during a conversion is dropped
      blank_lz = 1'b0; dp_mask = '0;
      send(500);
      repeat (3) @(negedge clk);
      in_data = IW'(42); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_ready();
      check_digits("t5", 8'hC0, 8'hC0, 8'h92, 8'hC0);

      // 6: reset in the middle of a conversion
      send(9999); wait_ready();
      send(1234);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t6_an", 32'(an), 32'hF);
      chk("t6_seg", 32'(seg), 32'hFF);
      chk("t6_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_digits("t6", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      chk("t6_ready_after", 32'(in_ready), 32'd1);
      chk("t6_ovf", 32'(overflow), 32'd0);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
